// File: rtl/efuse_pkg.sv
// Shared types and sizes for the efuse shadow loader.
package efuse_pkg;

    localparam int EFUSE_BITS = 256;
    localparam int TRIM_BITS  = 248;
    localparam int CHK_BYTE   = 31;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } shadow_st_e;

endpackage

// File: rtl/efuse_byte_sum.sv
// Byte-serial 8-bit checksum over the shadow image: one byte per step, B0 first.
module efuse_byte_sum
    import efuse_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic [EFUSE_BITS-1:0] i_image,
    output logic [7:0]            o_sum,
    output logic                  o_done
);

    logic [4:0] r_cnt;
    logic [7:0] r_acc;
    logic       r_done;
    logic [7:0] w_byte;

    assign w_byte = i_image[r_cnt*8 +: 8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
        end else if (i_step && !r_done) begin
            r_acc <= r_acc + w_byte;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(CHK_BYTE)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_sum  = r_acc;
    assign o_done = r_done;

endmodule

// File: rtl/efuse_shadow_load.sv
// Assembles the efuse autoload stream into a 256-bit shadow, verifies its byte checksum
// and publishes the verified trim image (with software override).
module efuse_shadow_load
    import efuse_pkg::*;
#(
    parameter  int                     NR       = 64,
    parameter  logic [TRIM_BITS-1:0]   DEF_TRIM = '0,
    localparam int                     NCH      = EFUSE_BITS / NR,
    localparam int                     IW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_vld,
    input  logic [IW-1:0]         load_idx,
    input  logic [NR-1:0]         load_data,
    input  logic                  load_done,
    input  logic                  rg_trim_ovr_en,
    input  logic [TRIM_BITS-1:0]  rg_trim_ovr_val,
    output logic [EFUSE_BITS-1:0] shadow_o,
    output logic [TRIM_BITS-1:0]  trim_o,
    output logic                  trim_vld,
    output logic                  chk_err,
    output logic                  shadow_busy
);

    shadow_st_e            r_state;
    logic [EFUSE_BITS-1:0] r_shadow;
    logic [NCH-1:0]        r_mask;
    logic [TRIM_BITS-1:0]  r_trim;
    logic                  r_trim_vld;
    logic                  r_chk_err;

    logic                  w_vld_ok;
    logic                  w_done_eval;
    logic [NCH-1:0]        w_mask_next;
    logic                  w_img_full;
    logic                  w_sum_start;
    logic                  w_sum_step;
    logic [7:0]            w_sum;
    logic                  w_sum_done;

    // A chunk arriving outside LOAD opens a new image, so its mask starts empty.
    // load_done is evaluated against the mask including a same-cycle chunk.
    assign w_vld_ok    = load_vld && (r_state != CHECK);
    assign w_done_eval = load_done && ((r_state == LOAD) || w_vld_ok);

    always_comb begin
        w_mask_next = (r_state == LOAD) ? r_mask : '0;
        if (w_vld_ok) begin
            w_mask_next[load_idx] = 1'b1;
        end
    end

    assign w_img_full  = &w_mask_next;
    assign w_sum_start = w_done_eval && w_img_full;
    assign w_sum_step  = (r_state == CHECK);

    efuse_byte_sum u_sum (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (w_sum_start),
        .i_step  (w_sum_step),
        .i_image (r_shadow),
        .o_sum   (w_sum),
        .o_done  (w_sum_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_mask     <= '0;
            r_trim     <= DEF_TRIM;
            r_trim_vld <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (w_sum_done) begin
                        if (w_sum == 8'h00) begin
                            r_state    <= DONE;
                            r_trim     <= r_shadow[TRIM_BITS-1:0];
                            r_trim_vld <= 1'b1;
                        end else begin
                            r_state   <= ERR;
                            r_chk_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_vld_ok) begin
                        r_shadow[load_idx*NR +: NR] <= load_data;
                        r_mask     <= w_mask_next;
                        r_trim_vld <= 1'b0;
                        r_chk_err  <= 1'b0;
                        r_state    <= LOAD;
                    end
                    if (w_done_eval) begin
                        if (w_img_full) begin
                            r_state <= CHECK;
                        end else begin
                            r_state   <= ERR;
                            r_chk_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign shadow_o    = r_shadow;
    assign trim_o      = rg_trim_ovr_en ? rg_trim_ovr_val : r_trim;
    assign trim_vld    = rg_trim_ovr_en | r_trim_vld;
    assign chk_err     = r_chk_err;
    assign shadow_busy = (r_state == LOAD) || (r_state == CHECK);

endmodule
